serdes_deser_param: RTL and testbench
=====================================

# serdes_deser_param

Parametrised serial-to-parallel receiver for the GJC IO test family. It samples one serial bit per `clkGHz` edge while enabled and assembles `WIDTH`-bit words, in LSB-first or MSB-first order. Each completed word is presented on `data_o` with a one-cycle `ready` strobe. It generalises the fixed 10-bit deserializer with a configurable width and bit order, a bitslip control for word-boundary adjustment, and an optional comma-based automatic word alignment.

## Interface
Parameters:
- `WIDTH`, 10 — word width in bits; legal range 2..32.
- `LSB_FIRST`, 1 — 1: first received bit lands in `data_o[0]`; 0: first received bit lands in `data_o[WIDTH-1]`.
- `COMMA`, 10'b0011111010 — alignment pattern in received-word orientation. Only used with `COMMA_ALIGN_EN`; must be `WIDTH` bits wide.

Ports:
- `clkGHz`  input  1  bit clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_i`  input  1  serial data, sampled on the rising edge of `clkGHz`.
- `enable_n`  input  1  active-low sample enable.
- `bitslip_i`  input  1  single-cycle request to delay the word boundary by one bit.
- `data_o`  output  `WIDTH`  last completed word; registered.
- `ready`  output  1  one-cycle strobe marking a new `data_o`.
- `aligned_o`  output  1  comma lock achieved; constant 0 without `COMMA_ALIGN_EN`.

## Operation
- Internal state:
  - shift window `win[WIDTH-1:0]`
  - bit counter `cnt`, range 0..`WIDTH-1`, `$clog2(WIDTH)` bits
  - registers for `data_o`, `ready`, `aligned_o`
- Reset (asynchronous, while `reset`=1): `win`=0, `cnt`=0, `data_o`=0, `ready`=0, `aligned_o`=0. Any partial word is discarded.
- Sample cycle is any rising edge with `enable_n`=0. On each sample cycle, `win` takes the next value `nxt`:
  - `LSB_FIRST`=1: `nxt` = {`data_i`, `win[WIDTH-1:1]`}
  - `LSB_FIRST`=0: `nxt` = {`win[WIDTH-2:0]`, `data_i`}
- Word completion: on a sample cycle with `cnt`=`WIDTH-1` and no bitslip, the block loads `data_o`←`nxt`, sets `ready`←1 and `cnt`←0.
- Other sample cycles without bitslip: `cnt`←`cnt`+1 and `ready`←0.
- Bitslip (sample cycle with `bitslip_i`=1):
  - The bit still enters `win`, but `cnt` holds and no word completes that cycle.
  - The effect is to move the boundary one bit later.
  - `aligned_o` is cleared.
- `enable_n`=1: `win`, `cnt` and `data_o` hold; `ready`←0; `bitslip_i` is ignored.
- `data_o` holds its value between words and is never cleared except by reset.

## Timing
- Latency: the WIDTH-th bit is sampled at edge N. `data_o` and `ready` become valid after edge N, and `ready` deasserts after edge N+1 unless another word completes there.
- Maximum rate: one word per `WIDTH` sample cycles, so `ready` is never high on two consecutive edges when `WIDTH`≥2.
- Gaps in `enable_n` stretch a word and do not reset `cnt`.
- Comma match vs bitslip in the same cycle: the comma match wins and bitslip is ignored.
- Reset asserted mid-word: all outputs return to their reset values immediately, without waiting for a clock edge.

## Configuration
- Macro `SERDES_DESER_COMMA_ALIGN_EN`.
- Defined:
  - Every sample cycle compares `nxt` with `COMMA`.
  - On a match: `data_o`←`COMMA`, `ready`←1, `cnt`←0, `aligned_o`←1, regardless of the current `cnt`. The word boundary re-aligns to the comma.
  - A match that coincides with a normal completion produces a single strobe.
  - `aligned_o` stays set until reset or bitslip.
- Not defined:
  - No comparator is present and `COMMA` is unused.
  - `aligned_o` is tied to 0.
  - Framing is set only by reset and `bitslip_i`.

## Test plan
- **Reset values:** `reset`=1 → `data_o`=0, `ready`=0, `aligned_o`=0. Assert `reset` mid-word for 1 ns with no clock edge → outputs return to 0 asynchronously; the next 10 bits form a complete word.
- **LSB-first word:** `WIDTH`=10, `LSB_FIRST`=1, `enable_n`=0, send 10'h17C LSB first → after the 10th edge `data_o`=10'h17C and `ready`=1 for exactly one cycle.
- **MSB-first word:** `LSB_FIRST`=0, send 10'h2A5 MSB first → `data_o`=10'h2A5. Back-to-back words 10'h001 then 10'h3FF → `ready` strobes 10 cycles apart.
- **Enable gaps:** hold `enable_n`=1 for 5 cycles after bit 4 of 10'h155 → `cnt` and `data_o` hold and `ready` stays 0; the word completes as 10'h155 after 10 sampled bits.
- **Bitslip:** stream repeating 10'h0F0, pulse `bitslip_i` once → the next word completes one sample later. The following words come out rotated by one bit: 10'h078 with `LSB_FIRST`=1.
- **Comma alignment (macro on):** random bits then `COMMA` at an arbitrary offset → `ready`=1 with `data_o`=10'b0011111010 and `aligned_o`=1 on the match edge. Later words stay framed; a `bitslip_i` pulse clears `aligned_o`.

Source files
------------

// File: rtl/serdes_deser_param.sv
// serdes_deser_param: serial-to-parallel receiver assembling WIDTH-bit words LSB- or MSB-first.
// Define SERDES_DESER_COMMA_ALIGN_EN to add automatic comma-based word alignment.
module serdes_deser_param #(
  parameter int              WIDTH     = 10,
  parameter int              LSB_FIRST = 1,
  parameter logic [WIDTH-1:0] COMMA    = WIDTH'(10'b0011111010)
) (
  input  logic             clkGHz,
  input  logic             reset,
  input  logic             data_i,
  input  logic             enable_n,
  input  logic             bitslip_i,
  output logic [WIDTH-1:0] data_o,
  output logic             ready,
  output logic             aligned_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready_q, ready_d;
  logic             aligned_q, aligned_d;
  logic [WIDTH-1:0] nxt;
  logic             comma_hit;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign nxt = {data_i, win_q[WIDTH-1:1]};
    end else begin : g_msb
      assign nxt = {win_q[WIDTH-2:0], data_i};
    end
  endgenerate

`ifdef SERDES_DESER_COMMA_ALIGN_EN
  assign comma_hit = (nxt == COMMA);
`else
  logic comma_unused;
  assign comma_unused = ^COMMA;
  assign comma_hit    = 1'b0;
`endif

  always_comb begin
    win_d     = win_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    aligned_d = aligned_q;
    if (!enable_n) begin
      win_d = nxt;
      // A comma match overrides both bitslip and the normal word boundary.
      if (comma_hit) begin
        data_d    = nxt;
        ready_d   = 1'b1;
        cnt_d     = '0;
        aligned_d = 1'b1;
      end else if (bitslip_i) begin
        aligned_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        data_d  = nxt;
        ready_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clkGHz or posedge reset) begin
    if (reset) begin
      win_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      aligned_q <= aligned_d;
    end
  end

  assign data_o    = data_q;
  assign ready     = ready_q;
  assign aligned_o = aligned_q;

endmodule

// File: tb/tb_serdes_deser_param.sv
// Scoreboard bench for serdes_deser_param: one LSB-first and one MSB-first instance.
`timescale 1ns/100ps
module tb_serdes_deser_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_l = 1'b0, en_l = 1'b1, slip_l = 1'b0;
  logic       din_m = 1'b0, en_m = 1'b1, slip_m = 1'b0;
  logic [9:0] dout_l, dout_m;
  logic       rdy_l, rdy_m, al_l, al_m;

  typedef struct packed {
    logic [9:0] d;
    logic       al;
    int         gap;
  } exp_t;

  exp_t q_l[$];
  exp_t q_m[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  serdes_deser_param #(.WIDTH(10), .LSB_FIRST(1)) dut_l (
    .clkGHz(clk), .reset(rst), .data_i(din_l), .enable_n(en_l), .bitslip_i(slip_l),
    .data_o(dout_l), .ready(rdy_l), .aligned_o(al_l));

  serdes_deser_param #(.WIDTH(10), .LSB_FIRST(0)) dut_m (
    .clkGHz(clk), .reset(rst), .data_i(din_m), .enable_n(en_m), .bitslip_i(slip_m),
    .data_o(dout_m), .ready(rdy_m), .aligned_o(al_m));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [9:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: ready strobe with data %0h but no word expected", name, act);
  endtask

  initial begin : mon_l
    int   last;
    logic prev;
    exp_t e;
    last = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else begin
        if (rdy_l) begin
          check("l_ready_one_cycle", {31'd0, prev}, 32'd0);
          if (q_l.size() == 0) unexpected("l_unexpected", dout_l);
          else begin
            e = q_l.pop_front();
            check("l_data", {22'd0, dout_l}, {22'd0, e.d});
            check("l_aligned", {31'd0, al_l}, {31'd0, e.al});
            if (e.gap != 0) check("l_gap", cyc - last, e.gap);
          end
          last = cyc;
        end
        prev = rdy_l;
      end
    end
  end

  initial begin : mon_m
    int   last;
    logic prev;
    exp_t e;
    last = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else begin
        if (rdy_m) begin
          check("m_ready_one_cycle", {31'd0, prev}, 32'd0);
          if (q_m.size() == 0) unexpected("m_unexpected", dout_m);
          else begin
            e = q_m.pop_front();
            check("m_data", {22'd0, dout_m}, {22'd0, e.d});
            check("m_aligned", {31'd0, al_m}, {31'd0, e.al});
            if (e.gap != 0) check("m_gap", cyc - last, e.gap);
          end
          last = cyc;
        end
        prev = rdy_m;
      end
    end
  end

  task automatic bit_l(input logic b, input logic en_n, input logic sl);
    @(negedge clk);
    din_l = b; en_l = en_n; slip_l = sl;
  endtask

  task automatic bit_m(input logic b, input logic en_n, input logic sl);
    @(negedge clk);
    din_m = b; en_m = en_n; slip_m = sl;
  endtask

  task automatic word_l(input logic [9:0] w);
    for (int i = 0; i < 10; i++) bit_l(w[i], 1'b0, 1'b0);
  endtask

  task automatic word_m(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) bit_m(w[i], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_l = 1'b1; slip_l = 1'b0;
      en_m = 1'b1; slip_m = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [9:0] w;
    logic [9:0] pat;
    logic [6:0] pre;
    #1;
    check("rst_data_l", {22'd0, dout_l}, 32'd0);
    check("rst_ready_l", {31'd0, rdy_l}, 32'd0);
    check("rst_aligned_l", {31'd0, al_l}, 32'd0);
    check("rst_data_m", {22'd0, dout_m}, 32'd0);
    check("rst_ready_m", {31'd0, rdy_m}, 32'd0);
    check("rst_aligned_m", {31'd0, al_m}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    q_l.push_back('{d: 10'h17C, al: 1'b0, gap: 0});
    word_l(10'h17C);
    idle(3);

    q_m.push_back('{d: 10'h2A5, al: 1'b0, gap: 0});
    q_m.push_back('{d: 10'h001, al: 1'b0, gap: 10});
    q_m.push_back('{d: 10'h3FF, al: 1'b0, gap: 10});
    word_m(10'h2A5);
    word_m(10'h001);
    word_m(10'h3FF);
    idle(3);

    // 0x155 with a 5-cycle enable gap after bit 4; junk data and a bitslip inside the gap
    w = 10'h155;
    q_l.push_back('{d: 10'h155, al: 1'b0, gap: 0});
    for (int i = 0; i < 5; i++) bit_l(w[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bit_l(i[0], 1'b1, (i == 2));
    for (int i = 5; i < 10; i++) bit_l(w[i], 1'b0, 1'b0);
    idle(3);
    check("gap_data_hold", {22'd0, dout_l}, 32'h155);

    w = 10'h3C3;
    for (int i = 0; i < 4; i++) bit_l(w[i], 1'b0, 1'b0);
    @(negedge clk);
    en_l = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async_rst_data_l", {22'd0, dout_l}, 32'd0);
    check("async_rst_ready_l", {31'd0, rdy_l}, 32'd0);
    check("async_rst_aligned_l", {31'd0, al_l}, 32'd0);
    check("async_rst_data_m", {22'd0, dout_m}, 32'd0);
    rst = 1'b0;
    q_l.push_back('{d: 10'h2B3, al: 1'b0, gap: 0});
    word_l(10'h2B3);
    idle(3);

    // repeating 0x0F0, bitslip on stream bit 23 delays the boundary by one sample
    pat = 10'h0F0;
    q_l.push_back('{d: 10'h0F0, al: 1'b0, gap: 0});
    q_l.push_back('{d: 10'h0F0, al: 1'b0, gap: 10});
    q_l.push_back('{d: 10'h078, al: 1'b0, gap: 11});
    q_l.push_back('{d: 10'h078, al: 1'b0, gap: 10});
    q_l.push_back('{d: 10'h078, al: 1'b0, gap: 10});
    for (int k = 0; k < 51; k++) bit_l(pat[k % 10], 1'b0, (k == 23));
    idle(3);

`ifdef SERDES_DESER_COMMA_ALIGN_EN
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    pre = 7'b1001101;
    q_l.push_back('{d: 10'h14D, al: 1'b0, gap: 0});
    q_l.push_back('{d: 10'h0FA, al: 1'b1, gap: 7});
    q_l.push_back('{d: 10'h17C, al: 1'b1, gap: 10});
    q_l.push_back('{d: 10'h17C, al: 1'b1, gap: 10});
    for (int i = 0; i < 7; i++) bit_l(pre[i], 1'b0, 1'b0);
    word_l(10'h0FA);
    word_l(10'h17C);
    word_l(10'h17C);
    bit_l(1'b1, 1'b0, 1'b1);
    idle(1);
    check("comma_slip_clears_aligned", {31'd0, al_l}, 32'd0);
    idle(2);
`else
    pre = 7'd0;
`endif

    for (int i = 0; i < 50 && (q_l.size() != 0 || q_m.size() != 0); i++) @(negedge clk);
    check("l_queue_drained", q_l.size(), 32'd0);
    check("m_queue_drained", q_m.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
